ifu_axi_fetch: RTL and testbench

- Instruction-fetch read master, directly upstream of the on-chip sram slave's read address and read data channels.
- Generates the sequential PC and issues one single-beat read per instruction.
- Returns each instruction to the decode stage through a valid/ready handshake.
- Handles pipeline redirects (flush) without breaking the channel protocol.

---
 rtl/ifu_axi_fetch_pkg.sv | 27 ++
 rtl/ifu_axi_fetch.sv | 122 ++++++++++++
 tb/tb_ifu_axi_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_axi_fetch_pkg.sv
// Shared definitions for the instruction-fetch read master: response codes,
// fetch FSM encoding and the default boot address.
package ifu_axi_fetch_pkg;

  localparam logic [2:0] RESP_OKAY = 3'b000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD,
    DROP = ST_DROP
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic resp_is_err(input logic [2:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch read master: sequential PC, one single-beat read in flight,
// valid/ready hand-off to decode and flush handling that drains orphaned beats.
module ifu_axi_fetch
  import ifu_axi_fetch_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [ADDR_LEN-1:0] flush_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic                inst_err,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_LEN-1:0] raddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [2:0]          rresp
);

  localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ~ADDR_LEN'(3);
  localparam logic [ADDR_LEN-1:0] INST_BYTES = ADDR_LEN'(4);

  fetch_state_e        state;
  logic [ADDR_LEN-1:0] pc;
  logic [ADDR_LEN-1:0] ar_addr;
  logic                drop;
  logic [ADDR_LEN-1:0] flush_tgt;
  logic [ADDR_LEN-1:0] pc_next_seq;

  assign flush_tgt   = flush_pc & ALIGN_MASK;
  assign pc_next_seq = pc + INST_BYTES;

  // Outputs decode straight from the state flop; raddr comes only from ar_addr.
  assign arvalid    = (state == REQ);
  assign rready     = (state == WAIT) || (state == DROP);
  assign inst_valid = (state == HOLD);
  assign raddr      = ar_addr & ALIGN_MASK;

  // Fetch FSM, PC and returned-instruction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ar_addr  <= RESET_PC;
      drop     <= 1'b0;
      inst     <= '0;
      inst_pc  <= '0;
      inst_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ar_addr <= pc;
          state   <= REQ;
        end
        REQ: begin
          // The address phase must complete even when redirected; the beat
          // it produces is then drained in DROP.
          if (arready) begin
            if (flush) begin
              pc <= flush_tgt;
            end
            state <= (drop || flush) ? DROP : WAIT;
          end else if (flush) begin
            pc   <= flush_tgt;
            drop <= 1'b1;
          end
        end
        WAIT: begin
          if (rvalid && !flush) begin
            inst     <= rdata;
            inst_pc  <= ar_addr;
            inst_err <= resp_is_err(rresp);
            state    <= HOLD;
          end else if (rvalid) begin
            pc      <= flush_tgt;
            ar_addr <= flush_tgt;
            state   <= REQ;
          end else if (flush) begin
            pc    <= flush_tgt;
            state <= DROP;
          end
        end
        DROP: begin
          if (rvalid) begin
            drop    <= 1'b0;
            ar_addr <= flush ? flush_tgt : pc;
            if (flush) begin
              pc <= flush_tgt;
            end
            state <= REQ;
          end else if (flush) begin
            pc <= flush_tgt;
          end
        end
        HOLD: begin
          if (flush) begin
            pc      <= flush_tgt;
            ar_addr <= flush_tgt;
            state   <= REQ;
          end else if (inst_ready) begin
            pc      <= pc_next_seq;
            ar_addr <= pc_next_seq;
            state   <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Self-checking bench for ifu_axi_fetch: table of fetches with a scoreboard
// queue, plus hand-written flush/reset sequences.
module tb_ifu_axi_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        arvalid;
  logic        arready;
  logic [31:0] raddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [2:0]  rresp;

  ifu_axi_fetch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err), .arvalid(arvalid),
    .arready(arready), .raddr(raddr), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdat;
    logic [2:0]  resp;
    int          ar_delay;
    int          hold;
    logic        do_flush;
    logic [31:0] fpc;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } sb_t;

  vec_t vecs[10];
  sb_t  sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arvalid();
    int n = 0;
    while (!arvalid && n < 20) begin
      step();
      n++;
    end
    chk("arvalid_seen", {31'd0, arvalid}, 32'd1);
  endtask

  task automatic fetch_one(input vec_t v);
    sb_t e;
    wait_arvalid();
    chk("raddr", raddr, v.exp_addr);
    for (int i = 0; i < v.ar_delay; i++) begin
      step();
      chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      chk("ar_hold_addr", raddr, v.exp_addr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("wait_arvalid_low", {31'd0, arvalid}, 32'd0);
    chk("wait_rready", {31'd0, rready}, 32'd1);
    chk("wait_no_inst", {31'd0, inst_valid}, 32'd0);
    rvalid = 1'b1;
    rdata  = v.rdat;
    rresp  = v.resp;
    sb.push_back('{inst: v.rdat, pc: v.exp_addr, err: v.exp_err});
    step();
    rvalid = 1'b0;
    rdata  = 32'd0;
    rresp  = 3'd0;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_err", {31'd0, inst_err}, {31'd0, e.err});
      for (int i = 0; i < v.hold; i++) begin
        step();
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_inst", inst, e.inst);
        chk("hold_pc", inst_pc, e.pc);
        chk("hold_no_ar", {31'd0, arvalid}, 32'd0);
      end
    end
    inst_ready = 1'b1;
    if (v.do_flush) begin
      flush    = 1'b1;
      flush_pc = v.fpc;
    end
    step();
    inst_ready = 1'b0;
    flush      = 1'b0;
    chk("accept_clr", {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fetch_one(vecs[i]);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0013, 3'b000, 0, 0, 1'b0, 32'h0, 32'h8000_0000, 1'b0};
    vecs[1] = '{32'h0000_0013, 3'b000, 0, 0, 1'b0, 32'h0, 32'h8000_0004, 1'b0};
    vecs[2] = '{32'h0010_0093, 3'b010, 0, 0, 1'b0, 32'h0, 32'h8000_0008, 1'b1};
    vecs[3] = '{32'h1234_5678, 3'b000, 0, 5, 1'b0, 32'h0, 32'h8000_000C, 1'b0};
    vecs[4] = '{32'hDEAD_BEEF, 3'b100, 2, 1, 1'b0, 32'h0, 32'h8000_0010, 1'b1};
    vecs[5] = '{32'hABCD_0001, 3'b000, 0, 0, 1'b1, 32'hFFFF_FFFE, 32'h8000_0100, 1'b0};
    vecs[6] = '{32'h1111_2222, 3'b000, 0, 0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0};
    vecs[7] = '{32'h3333_4444, 3'b001, 0, 0, 1'b0, 32'h0, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0055, 3'b000, 0, 0, 1'b0, 32'h0, 32'h8000_0300, 1'b0};
    vecs[9] = '{32'h0000_0066, 3'b000, 0, 0, 1'b0, 32'h0, 32'h8000_0000, 1'b0};

    rst_n = 1'b0; flush = 1'b0; flush_pc = 32'd0; inst_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 3'd0;
    step();
    step();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    rst_n = 1'b1;

    run_range(0, 4);

    // Flush while the address phase is stalled: address stays, beat is drained.
    wait_arvalid();
    chk("fa_raddr", raddr, 32'h8000_0014);
    flush = 1'b1;
    flush_pc = 32'h8000_0101;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("fa_arvalid_stable", {31'd0, arvalid}, 32'd1);
      chk("fa_raddr_stable", raddr, 32'h8000_0014);
      step();
    end
    chk("fa_raddr_stable", raddr, 32'h8000_0014);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("fa_drop_rready", {31'd0, rready}, 32'd1);
    chk("fa_drop_no_ar", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1;
    rdata = 32'hBAD0_BAD0;
    step();
    rvalid = 1'b0;
    chk("fa_discard", {31'd0, inst_valid}, 32'd0);
    chk("fa_next_raddr", raddr, 32'h8000_0100);

    // Accept with redirect to the top of memory, then wrap past it.
    run_range(5, 7);

    // Flush in WAIT one cycle before the beat.
    wait_arvalid();
    chk("fb_raddr", raddr, 32'h0000_0004);
    arready = 1'b1;
    step();
    arready = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h8000_0200;
    step();
    flush = 1'b0;
    chk("fb_drop_rready", {31'd0, rready}, 32'd1);
    chk("fb_drop_no_ar", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    chk("fb_discard", {31'd0, inst_valid}, 32'd0);
    chk("fb_next_raddr", raddr, 32'h8000_0200);

    // Flush coincident with the beat: straight back to REQ.
    wait_arvalid();
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h8000_0300;
    step();
    rvalid = 1'b0;
    flush = 1'b0;
    chk("fc_discard", {31'd0, inst_valid}, 32'd0);
    chk("fc_arvalid", {31'd0, arvalid}, 32'd1);
    chk("fc_raddr", raddr, 32'h8000_0300);

    run_range(8, 8);

    // Reset mid-WAIT abandons the transaction and restarts at the boot PC.
    wait_arvalid();
    chk("fr_raddr", raddr, 32'h8000_0304);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("fr_arvalid", {31'd0, arvalid}, 32'd0);
    chk("fr_rready", {31'd0, rready}, 32'd0);
    chk("fr_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst_n = 1'b1;

    run_range(9, 9);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
